// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types for the LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_APPLY = 1'b1
  } wr_state_t;

endpackage

// File: rtl/led_chan.sv
// rtl/led_chan.sv - one LED channel: divider, blink phase, breathe ramp, output mux.
// Breathe ramp present only when LED_BREATHE_EN is defined; otherwise mode 3 blinks.
module led_chan
  import led_pkg::*;
#(
  parameter int CNT_W = 25
`ifdef LED_BREATHE_EN
  , parameter int PWM_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  led_mode_t        mode_in,
  input  logic [CNT_W-1:0] div_in,
`ifdef LED_BREATHE_EN
  input  logic [PWM_W-1:0] pwm,
`endif
  output logic             led
);

  led_mode_t        mode;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             step;
  logic             led_next;

  assign step = (cnt == div);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode  <= LED_OFF;
      div   <= '1;
      cnt   <= '0;
      phase <= 1'b0;
      led   <= 1'b0;
    end else begin
      led <= led_next;
      if (commit) begin
        mode  <= mode_in;
        div   <= div_in;
        cnt   <= '0;
        phase <= 1'b0;
      end else begin
        cnt <= step ? '0 : cnt + CNT_W'(1);
        if (step) phase <= ~phase;
      end
    end
  end

`ifdef LED_BREATHE_EN
  localparam logic [PWM_W-1:0] LEVEL_MAX = '1;

  logic [PWM_W-1:0] level;
  logic             dir_up;

  // Triangle ramp: bounces off both ends so each extreme is held for one step only.
  always_ff @(posedge clk) begin
    if (rst || commit) begin
      level  <= '0;
      dir_up <= 1'b1;
    end else if (step) begin
      if (dir_up) begin
        if (level == LEVEL_MAX) begin
          dir_up <= 1'b0;
          level  <= level - PWM_W'(1);
        end else begin
          level <= level + PWM_W'(1);
        end
      end else begin
        if (level == '0) begin
          dir_up <= 1'b1;
          level  <= PWM_W'(1);
        end else begin
          level <= level - PWM_W'(1);
        end
      end
    end
  end
`endif

  always_comb begin
    led_next = 1'b0;
    case (mode)
      LED_OFF:     led_next = 1'b0;
      LED_ON:      led_next = 1'b1;
      LED_BLINK:   led_next = phase;
`ifdef LED_BREATHE_EN
      LED_BREATHE: led_next = (pwm < level);
`else
      LED_BREATHE: led_next = phase;
`endif
      default:     led_next = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED pattern generator with valid/ready config port.
// Define LED_BREATHE_EN to build the triangle-ramped PWM breathe mode and shared PWM counter.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 25,
  parameter int PWM_W    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [1:0]                            cfg_mode,
  input  logic [CNT_W-1:0]                      cfg_div,
  output logic [CHANNELS-1:0]                   blink
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  wr_state_t         state;
  logic [CHAN_W-1:0] lat_chan;
  led_mode_t         lat_mode;
  logic [CNT_W-1:0]  lat_div;
  logic [CHANNELS-1:0] commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WR_IDLE;
      cfg_ready <= 1'b0;
      lat_chan  <= '0;
      lat_mode  <= LED_OFF;
      lat_div   <= '0;
    end else begin
      case (state)
        WR_IDLE: begin
          if (cfg_valid && cfg_ready) begin
            lat_chan  <= cfg_chan;
            lat_mode  <= led_mode_t'(cfg_mode);
            lat_div   <= cfg_div;
            state     <= WR_APPLY;
            cfg_ready <= 1'b0;
          end else begin
            cfg_ready <= 1'b1;
          end
        end
        WR_APPLY: begin
          state     <= WR_IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= WR_IDLE;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0] pwm;

  always_ff @(posedge clk) begin
    if (rst) pwm <= '0;
    else     pwm <= pwm + PWM_W'(1);
  end
`endif

  // An out-of-range channel index matches no select line, so the write is simply dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign commit[i] = (state == WR_APPLY) && (lat_chan == CHAN_W'(i));

    led_chan #(
      .CNT_W (CNT_W)
`ifdef LED_BREATHE_EN
      , .PWM_W (PWM_W)
`endif
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .commit  (commit[i]),
      .mode_in (lat_mode),
      .div_in  (lat_div),
`ifdef LED_BREATHE_EN
      .pwm     (pwm),
`endif
      .led     (blink[i])
    );
  end

endmodule
